amiq_mux2_1_arbiter: RTL and testbench

Controller that shares the amiq_mux2_1 datapath between two requesters.
Each requester asks for ownership for a number of cycles. The arbiter grants round-robin, drives sel plus the owner's data onto in0/in1, and inserts guard cycles between ownerships.
It sits between the stimulus sources and the mux instance in amiq_top and replaces the free-running drive_sel/drive_in0/drive_in1 tasks.

---
 rtl/amiq_mux2_1_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_amiq_mux2_1_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amiq_mux2_1_arbiter.sv
// Round-robin owner of the shared amiq_mux2_1 datapath.
// Two requesters ask for the mux for a number of cycles. The winner
// drives sel and its own data input. A configurable run of guard cycles
// separates consecutive ownerships. Every output comes straight from a flop.
module amiq_mux2_1_arbiter #(
    parameter int LEN_W     = 4,
    parameter int GUARD_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [LEN_W-1:0] len0,
    input  logic             dat0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len1,
    input  logic             dat1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             sel,
    output logic             in0,
    output logic             in1,
    output logic             busy
);

    localparam int GCNT_W = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
    localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(GUARD_CYC);
    localparam logic [GCNT_W-1:0] GCNT_ONE   = GCNT_W'(1);
    localparam logic [LEN_W-1:0]  CNT_ONE    = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic                last_q, last_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                sel_q, sel_d;
    logic                in0_q, in0_d;
    logic                in1_q, in1_d;
    logic                busy_q, busy_d;

    logic                win;
    logic [LEN_W-1:0]    win_len;
    logic                owner_req;
    logic                end_grant;

    // Next-state logic: arbitrate in IDLE, count the burst in GRANT, count guard cycles in GUARD.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        last_d    = last_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        sel_d     = sel_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        busy_d    = busy_q;
        win       = 1'b0;
        win_len   = '0;
        owner_req = 1'b0;
        end_grant = 1'b0;

        case (state_q)
            IDLE: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                busy_d = 1'b0;
                if (req0 || req1) begin
                    // On a tie the requester that did not own the mux last time wins.
                    win     = (req0 && req1) ? ~last_q : req1;
                    win_len = win ? len1 : len0;
                    state_d = GRANT;
                    sel_d   = win;
                    last_d  = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    busy_d  = 1'b1;
                    cnt_d   = (win_len == '0) ? CNT_ONE : win_len;
                end
            end

            GRANT: begin
                owner_req = sel_q ? req1 : req0;
                if (!owner_req) begin
                    // Owner withdrew: release silently, leave its input as last driven.
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    end_grant = 1'b1;
                end else begin
                    if (sel_q) begin
                        in1_d = dat1;
                    end else begin
                        in0_d = dat0;
                    end
                    if (cnt_q == CNT_ONE) begin
                        gnt0_d    = 1'b0;
                        gnt1_d    = 1'b0;
                        done0_d   = ~sel_q;
                        done1_d   = sel_q;
                        end_grant = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            GUARD: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                if (gcnt_q == GCNT_ONE) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q - GCNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Any end of ownership goes to GUARD, or straight to IDLE when no guard is configured.
        if (end_grant) begin
            if (GUARD_CYC > 0) begin
                state_d = GUARD;
                gcnt_d  = GUARD_LOAD;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset; requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            sel_q   <= 1'b0;
            in0_q   <= 1'b0;
            in1_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            sel_q   <= sel_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign sel   = sel_q;
    assign in0   = in0_q;
    assign in1   = in1_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_amiq_mux2_1_arbiter.sv
// Directed bench for amiq_mux2_1_arbiter (LEN_W=4, GUARD_CYC=1).
// Inputs change on the falling edge and outputs are sampled there too.
// Output vectors are packed as {gnt0,gnt1,done0,done1,sel,in0,in1,busy}.
module tb_amiq_mux2_1_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, dat0, dat1;
    logic [3:0] len0, len1;
    logic       gnt0, gnt1, done0, done1, sel, in0, in1, busy;

    int errors = 0;
    int checks = 0;

    amiq_mux2_1_arbiter #(.LEN_W(4), .GUARD_CYC(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .len0  (len0),
        .dat0  (dat0),
        .req1  (req1),
        .len1  (len1),
        .dat1  (dat1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .sel   (sel),
        .in0   (in0),
        .in1   (in1),
        .busy  (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {gnt0, gnt1, done0, done1, sel, in0, in1, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        dat0 = 1'b0; dat1 = 1'b0;
        len0 = 4'd0; len1 = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        reset_dut();
        for (int i = 0; i <= 10; i++) begin
            o = outs();
            checks++;
            if (o !== 8'b0000_0000) begin
                errors++;
                $display("[TB] FAIL reset_idle cyc%0d: got %b expected %b", i, o, 8'b0);
            end
            tick();
        end
    endtask

    task automatic test_single_burst();
        logic [7:0] exp_v [0:5];
        logic [7:0] o;
        exp_v[0] = 8'b1000_0001;
        exp_v[1] = 8'b1000_0101;
        exp_v[2] = 8'b1000_0001;
        exp_v[3] = 8'b0010_0101;
        exp_v[4] = 8'b0000_0100;
        exp_v[5] = 8'b0000_0100;
        reset_dut();
        req0 = 1'b1; len0 = 4'd3; dat0 = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            o = outs();
            checks++;
            if (o !== exp_v[i]) begin
                errors++;
                $display("[TB] FAIL single_burst cyc%0d: got %b expected %b", i, o, exp_v[i]);
            end
            case (i)
                0: dat0 = 1'b1;
                1: dat0 = 1'b0;
                2: dat0 = 1'b1;
                3: req0 = 1'b0;
                default: ;
            endcase
            tick();
        end
    endtask

    task automatic test_tie_alternation();
        logic [7:0] exp_v;
        logic [7:0] o;
        reset_dut();
        req0 = 1'b1; req1 = 1'b1;
        len0 = 4'd2; len1 = 4'd4;
        tick();
        for (int k = 0; k < 30; k++) begin
            case (k % 10)
                0, 1:       exp_v = 8'b1000_0001;
                2:          exp_v = 8'b0010_0001;
                3:          exp_v = 8'b0000_0000;
                4, 5, 6, 7: exp_v = 8'b0100_1001;
                8:          exp_v = 8'b0001_1001;
                default:    exp_v = 8'b0000_1000;
            endcase
            o = outs();
            checks++;
            if (o !== exp_v) begin
                errors++;
                $display("[TB] FAIL tie_alternation cyc%0d: got %b expected %b", k, o, exp_v);
            end
            checks++;
            if ((gnt0 & gnt1) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mutual_exclusion cyc%0d: got gnt0=%b gnt1=%b expected not both 1", k, gnt0, gnt1);
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] exp_v [0:5];
        logic [7:0] o;
        exp_v[0] = 8'b0100_1001;
        exp_v[1] = 8'b0100_1001;
        exp_v[2] = 8'b0100_1011;
        exp_v[3] = 8'b0000_1011;
        exp_v[4] = 8'b0000_1010;
        exp_v[5] = 8'b0000_1010;
        reset_dut();
        req1 = 1'b1; len1 = 4'd8; dat1 = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            o = outs();
            checks++;
            if (o !== exp_v[i]) begin
                errors++;
                $display("[TB] FAIL abort cyc%0d: got %b expected %b", i, o, exp_v[i]);
            end
            case (i)
                0: dat1 = 1'b0;
                1: dat1 = 1'b1;
                2: begin req1 = 1'b0; dat1 = 1'b1; end
                default: ;
            endcase
            tick();
        end
    endtask

    task automatic test_len_limits();
        logic [7:0] o;
        reset_dut();
        req0 = 1'b1; len0 = 4'd0;
        tick();
        o = outs();
        checks++;
        if (o !== 8'b1000_0001) begin
            errors++;
            $display("[TB] FAIL len0_grant: got %b expected %b", o, 8'b1000_0001);
        end
        tick();
        o = outs();
        checks++;
        if (o !== 8'b0010_0001) begin
            errors++;
            $display("[TB] FAIL len0_done: got %b expected %b", o, 8'b0010_0001);
        end
        req0 = 1'b0;
        tick();
        o = outs();
        checks++;
        if (o !== 8'b0000_0000) begin
            errors++;
            $display("[TB] FAIL len0_idle: got %b expected %b", o, 8'b0);
        end
        req0 = 1'b1; len0 = 4'd15;
        tick();
        for (int i = 0; i < 15; i++) begin
            o = outs();
            checks++;
            if (o !== 8'b1000_0001) begin
                errors++;
                $display("[TB] FAIL len15_grant cyc%0d: got %b expected %b", i, o, 8'b1000_0001);
            end
            tick();
        end
        o = outs();
        checks++;
        if (o !== 8'b0010_0001) begin
            errors++;
            $display("[TB] FAIL len15_done: got %b expected %b", o, 8'b0010_0001);
        end
        req0 = 1'b0;
        tick();
        o = outs();
        checks++;
        if (o !== 8'b0000_0000) begin
            errors++;
            $display("[TB] FAIL len15_idle: got %b expected %b", o, 8'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] o;
        reset_dut();
        req0 = 1'b1; len0 = 4'd5; dat0 = 1'b1;
        tick();
        o = outs();
        checks++;
        if (o !== 8'b1000_0001) begin
            errors++;
            $display("[TB] FAIL midrst_grant1: got %b expected %b", o, 8'b1000_0001);
        end
        tick();
        o = outs();
        checks++;
        if (o !== 8'b1000_0101) begin
            errors++;
            $display("[TB] FAIL midrst_grant2: got %b expected %b", o, 8'b1000_0101);
        end
        rst = 1'b1;
        tick();
        o = outs();
        checks++;
        if (o !== 8'b0000_0000) begin
            errors++;
            $display("[TB] FAIL midrst_cleared: got %b expected %b", o, 8'b0);
        end
        rst = 1'b0;
        tick();
        o = outs();
        checks++;
        if (o !== 8'b1000_0001) begin
            errors++;
            $display("[TB] FAIL midrst_regrant: got %b expected %b", o, 8'b1000_0001);
        end
        tick();
        o = outs();
        checks++;
        if (o !== 8'b1000_0101) begin
            errors++;
            $display("[TB] FAIL midrst_regrant_data: got %b expected %b", o, 8'b1000_0101);
        end
        req0 = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        dat0 = 1'b0; dat1 = 1'b0;
        len0 = 4'd0; len1 = 4'd0;
        @(negedge clk);
        test_reset();
        test_single_burst();
        test_tie_alternation();
        test_abort();
        test_len_limits();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
